// File: rtl/fu_issue_scheduler_pkg.sv
// Shared types and limits for the functional-unit issue scheduler.
package fu_issue_scheduler_pkg;

   localparam int CNT_W      = 3;
   localparam int FU_LAT_MAX = 7;

   typedef logic [CNT_W-1:0] fu_sched_cnt_t;

endpackage

// File: rtl/fu_issue_scheduler_if.sv
// Issue/CDB handshake bundle between the reservation stations and the scheduler.
interface fu_issue_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int NUM_FU  = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
);

   logic                      flush;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_FU-1:0]         cdb_ready;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_FU-1:0]         issue_valid;
   logic [NUM_FU*IDX_W-1:0]   issue_idx;
   logic [NUM_FU-1:0]         fu_busy;
   logic [NUM_FU-1:0]         fu_done;

   modport master (
      output flush, req, cdb_ready,
      input  gnt, issue_valid, issue_idx, fu_busy, fu_done
   );

   modport slave (
      input  flush, req, cdb_ready,
      output gnt, issue_valid, issue_idx, fu_busy, fu_done
   );

endinterface

// File: rtl/fu_issue_scheduler_rr_multi_picker.sv
// Rotate-and-priority encoder: picks up to NUM_PICK set request bits,
// scanning upward from rr_ptr with wrap, in scan order.
module rr_multi_picker #(
   parameter int NUM_REQ  = 4,
   parameter int NUM_PICK = 2,
   parameter int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]          req,
   input  logic [IDX_W-1:0]            rr_ptr,
   output logic [NUM_PICK*IDX_W-1:0]   pick_idx,
   output logic [NUM_PICK-1:0]         pick_valid
);

   logic [2*NUM_REQ-1:0] dbl_s;
   logic [NUM_REQ-1:0]   rot_s;

   // Bit j of rot_s is the request at position rr_ptr+j (mod NUM_REQ)
   assign dbl_s = {req, req} >> rr_ptr;
   assign rot_s = dbl_s[NUM_REQ-1:0];

   // Each pick slot takes the lowest remaining rotated bit and removes it
   always_comb begin
      logic [NUM_REQ-1:0] left_v;
      logic               found_v;
      int                 sum_v;
      left_v     = rot_s;
      found_v    = 1'b0;
      sum_v      = 0;
      pick_idx   = '0;
      pick_valid = '0;
      for (int k = 0; k < NUM_PICK; k++) begin
         found_v = 1'b0;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (left_v[j] && !found_v) begin
               found_v       = 1'b1;
               left_v[j]     = 1'b0;
               sum_v         = int'(rr_ptr) + j;
               pick_valid[k] = 1'b1;
               pick_idx[k*IDX_W +: IDX_W] =
                  IDX_W'((sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v);
            end else begin
               found_v = found_v;
            end
         end
      end
   end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Shares NUM_FU non-pipelined functional units among NUM_REQ issue ports:
// per-FU occupancy counters, round-robin grant, result hold until CDB accept.
module fu_issue_scheduler
   import fu_issue_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_FU  = 2,
   parameter int FU_LAT  = 1,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   fu_issue_scheduler_if.slave   bus
);

   localparam fu_sched_cnt_t LAT_CNT =
      fu_sched_cnt_t'((FU_LAT > FU_LAT_MAX) ? FU_LAT_MAX : FU_LAT);

   fu_sched_cnt_t             cnt_r [NUM_FU];
   logic [IDX_W-1:0]          rr_ptr_r;
   logic [NUM_FU-1:0]         avail_s;
   logic [NUM_FU*IDX_W-1:0]   pick_idx_s;
   logic [NUM_FU-1:0]         pick_valid_s;
   logic [NUM_REQ-1:0]        gnt_s;
   logic [NUM_FU-1:0]         issue_valid_s;
   logic [NUM_FU*IDX_W-1:0]   issue_idx_s;
   logic                      grant_any_s;
   logic [IDX_W-1:0]          last_idx_s;
   logic [IDX_W-1:0]          next_ptr_s;
   logic [NUM_FU-1:0]         fu_busy_s;
   logic [NUM_FU-1:0]         fu_done_s;

   rr_multi_picker #(
      .NUM_REQ  (NUM_REQ),
      .NUM_PICK (NUM_FU),
      .IDX_W    (IDX_W)
   ) u_picker (
      .req        (bus.req),
      .rr_ptr     (rr_ptr_r),
      .pick_idx   (pick_idx_s),
      .pick_valid (pick_valid_s)
   );

   // An FU takes a new op when idle, or when its held result leaves on the CDB this cycle
   always_comb begin
      for (int f = 0; f < NUM_FU; f++) begin
         avail_s[f] = (cnt_r[f] == 3'd0) || ((cnt_r[f] == 3'd1) && bus.cdb_ready[f]);
      end
   end

   // Bind the k-th pick in scan order to the k-th available FU; flush or reset blocks all issue
   always_comb begin
      int               k_v;
      logic [IDX_W-1:0] idx_v;
      logic             vld_v;
      k_v           = 0;
      idx_v         = '0;
      vld_v         = 1'b0;
      gnt_s         = '0;
      issue_valid_s = '0;
      issue_idx_s   = '0;
      grant_any_s   = 1'b0;
      last_idx_s    = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         idx_v = IDX_W'(pick_idx_s >> (k_v * IDX_W));
         vld_v = 1'(pick_valid_s >> k_v);
         if (rst && !bus.flush && avail_s[f] && vld_v) begin
            gnt_s[idx_v]                   = 1'b1;
            issue_valid_s[f]               = 1'b1;
            issue_idx_s[f*IDX_W +: IDX_W]  = idx_v;
            grant_any_s                    = 1'b1;
            last_idx_s                     = idx_v;
            k_v                            = k_v + 1;
         end else begin
            k_v = k_v;
         end
      end
   end

   // Pointer resumes just after the last requester served, wrapping at NUM_REQ
   always_comb begin
      if (last_idx_s == IDX_W'(NUM_REQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = last_idx_s + IDX_W'(1);
      end
   end

   // Round-robin pointer advances only when something was granted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= '0;
      end else if (grant_any_s) begin
         rr_ptr_r <= next_ptr_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Occupancy counters: load on issue, count down, stall at 1 until the CDB accepts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int f = 0; f < NUM_FU; f++) begin
            cnt_r[f] <= '0;
         end
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            if (bus.flush) begin
               cnt_r[f] <= '0;
            end else if (issue_valid_s[f]) begin
               cnt_r[f] <= LAT_CNT;
            end else if ((cnt_r[f] == 3'd1) && bus.cdb_ready[f]) begin
               cnt_r[f] <= '0;
            end else if (cnt_r[f] > 3'd1) begin
               cnt_r[f] <= cnt_r[f] - 3'd1;
            end else begin
               cnt_r[f] <= cnt_r[f];
            end
         end
      end
   end

   // Status flags come straight from the counter registers
   always_comb begin
      for (int f = 0; f < NUM_FU; f++) begin
         fu_busy_s[f] = (cnt_r[f] != 3'd0);
         fu_done_s[f] = (cnt_r[f] == 3'd1);
      end
   end

   assign bus.gnt         = gnt_s;
   assign bus.issue_valid = issue_valid_s;
   assign bus.issue_idx   = issue_idx_s;
   assign bus.fu_busy     = fu_busy_s;
   assign bus.fu_done     = fu_done_s;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Bench for fu_issue_scheduler: three configurations driven in parallel,
// directed scenarios plus randomized traffic against a queue-based model.
module tb_fu_issue_scheduler;

   localparam int NR = 4;
   localparam int NI = 3;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [3:0] req;
   logic [1:0] cdb;
   int         n_pass;
   int         n_total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fu_issue_scheduler_if #(.NUM_REQ(4), .NUM_FU(2), .IDX_W(2)) if_a ();
   fu_issue_scheduler_if #(.NUM_REQ(4), .NUM_FU(2), .IDX_W(2)) if_b ();
   fu_issue_scheduler_if #(.NUM_REQ(4), .NUM_FU(1), .IDX_W(2)) if_c ();

   assign if_a.flush = flush;  assign if_a.req = req;  assign if_a.cdb_ready = cdb;
   assign if_b.flush = flush;  assign if_b.req = req;  assign if_b.cdb_ready = cdb;
   assign if_c.flush = flush;  assign if_c.req = req;  assign if_c.cdb_ready = cdb[0];

   fu_issue_scheduler #(.NUM_REQ(4), .NUM_FU(2), .FU_LAT(1), .IDX_W(2))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   fu_issue_scheduler #(.NUM_REQ(4), .NUM_FU(2), .FU_LAT(3), .IDX_W(2))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   fu_issue_scheduler #(.NUM_REQ(4), .NUM_FU(1), .FU_LAT(1), .IDX_W(2))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));

   // Observed outputs, widened to a common shape per instance
   logic [3:0] o_gnt [NI];
   logic [1:0] o_iv [NI];
   logic [3:0] o_idx [NI];
   logic [1:0] o_busy [NI];
   logic [1:0] o_done [NI];

   assign o_gnt[0] = if_a.gnt;  assign o_iv[0] = if_a.issue_valid;  assign o_idx[0] = if_a.issue_idx;
   assign o_busy[0] = if_a.fu_busy;  assign o_done[0] = if_a.fu_done;
   assign o_gnt[1] = if_b.gnt;  assign o_iv[1] = if_b.issue_valid;  assign o_idx[1] = if_b.issue_idx;
   assign o_busy[1] = if_b.fu_busy;  assign o_done[1] = if_b.fu_done;
   assign o_gnt[2] = if_c.gnt;  assign o_iv[2] = {1'b0, if_c.issue_valid};
   assign o_idx[2] = {2'b00, if_c.issue_idx};
   assign o_busy[2] = {1'b0, if_c.fu_busy};  assign o_done[2] = {1'b0, if_c.fu_done};

   // Reference model: remaining-cycles per FU and a scan start per instance
   int nfu [NI] = '{2, 2, 1};
   int lat [NI] = '{1, 3, 1};
   int m_cnt [NI][2];
   int m_ptr [NI];
   int m_last [NI];
   logic [3:0] e_gnt [NI];
   logic [1:0] e_iv [NI];
   logic [3:0] e_idx [NI];
   logic [1:0] e_busy [NI];
   logic [1:0] e_done [NI];

   function automatic void model_eval();
      int order[$];
      int fus[$];
      int np;
      for (int n = 0; n < NI; n++) begin
         if (rst !== 1'b1) begin
            m_ptr[n] = 0;
            m_cnt[n][0] = 0;
            m_cnt[n][1] = 0;
         end
         order.delete();
         fus.delete();
         e_gnt[n] = 4'b0000; e_iv[n] = 2'b00; e_idx[n] = 4'b0000;
         e_busy[n] = 2'b00;  e_done[n] = 2'b00;
         m_last[n] = -1;
         for (int f = 0; f < nfu[n]; f++) begin
            e_busy[n][f] = (m_cnt[n][f] != 0);
            e_done[n][f] = (m_cnt[n][f] == 1);
         end
         if (rst === 1'b1 && flush === 1'b0) begin
            for (int j = 0; j < NR; j++) begin
               if (req[(m_ptr[n] + j) % NR]) order.push_back((m_ptr[n] + j) % NR);
            end
            for (int f = 0; f < nfu[n]; f++) begin
               if (m_cnt[n][f] == 0 || (m_cnt[n][f] == 1 && cdb[f])) fus.push_back(f);
            end
            np = (order.size() < fus.size()) ? order.size() : fus.size();
            for (int k = 0; k < np; k++) begin
               e_gnt[n][order[k]] = 1'b1;
               e_iv[n][fus[k]] = 1'b1;
               e_idx[n][fus[k]*2 +: 2] = 2'(order[k]);
               m_last[n] = order[k];
            end
         end
      end
   endfunction

   function automatic void model_update();
      for (int n = 0; n < NI; n++) begin
         if (rst !== 1'b1) begin
            m_ptr[n] = 0;
            m_cnt[n][0] = 0;
            m_cnt[n][1] = 0;
         end else begin
            for (int f = 0; f < nfu[n]; f++) begin
               if (flush) m_cnt[n][f] = 0;
               else if (e_iv[n][f]) m_cnt[n][f] = lat[n];
               else if (m_cnt[n][f] == 1 && cdb[f]) m_cnt[n][f] = 0;
               else if (m_cnt[n][f] > 1) m_cnt[n][f] = m_cnt[n][f] - 1;
            end
            if (m_last[n] >= 0) m_ptr[n] = (m_last[n] + 1) % NR;
         end
      end
   endfunction

   task automatic step();
      model_eval();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; req = 4'b0000; flush = 1'b0; cdb = 2'b00;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; req = 4'b1111; cdb = 2'b11;
      #1;
      for (int n = 0; n < NI; n++) begin
         n_total++; if (o_gnt[n] !== 4'b0000) $display("FAIL reset_gnt inst%0d: got %b want 0000", n, o_gnt[n]); else n_pass++;
         n_total++; if (o_iv[n] !== 2'b00) $display("FAIL reset_iv inst%0d: got %b want 00", n, o_iv[n]); else n_pass++;
         n_total++; if (o_busy[n] !== 2'b00) $display("FAIL reset_busy inst%0d: got %b want 00", n, o_busy[n]); else n_pass++;
         n_total++; if (o_done[n] !== 2'b00) $display("FAIL reset_done inst%0d: got %b want 00", n, o_done[n]); else n_pass++;
      end
      step();
   endtask

   task automatic test_basic_issue();
      do_reset();
      req = 4'b0101; cdb = 2'b11;
      #1;
      n_total++; if (o_gnt[0] !== 4'b0101) $display("FAIL basic_gnt: got %b want 0101", o_gnt[0]); else n_pass++;
      n_total++; if (o_iv[0] !== 2'b11) $display("FAIL basic_iv: got %b want 11", o_iv[0]); else n_pass++;
      n_total++; if (o_idx[0] !== 4'b1000) $display("FAIL basic_idx: got %b want 1000", o_idx[0]); else n_pass++;
      step();
      req = 4'b0000;
      #1;
      n_total++; if (o_done[0] !== 2'b11) $display("FAIL basic_done: got %b want 11", o_done[0]); else n_pass++;
      req = 4'b1001;
      #1;
      n_total++; if (o_gnt[0] !== 4'b1001) $display("FAIL basic_ptr_gnt: got %b want 1001", o_gnt[0]); else n_pass++;
      n_total++; if (o_idx[0] !== 4'b0011) $display("FAIL basic_ptr_idx: got %b want 0011", o_idx[0]); else n_pass++;
      step();
      req = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [3] = '{4'b0011, 4'b1100, 4'b0011};
      logic [3:0] seen;
      seen = 4'b0000;
      do_reset();
      req = 4'b1111; cdb = 2'b11;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_total++; if (o_gnt[0] !== exp_seq[c]) $display("FAIL rr_gnt cyc%0d: got %b want %b", c, o_gnt[0], exp_seq[c]); else n_pass++;
         if (c < 2) seen = seen | o_gnt[0];
         step();
      end
      n_total++; if (seen !== 4'b1111) $display("FAIL rr_fair: got %b want 1111", seen); else n_pass++;
      req = 4'b0000;
   endtask

   task automatic test_backpressure();
      logic exp_b;
      do_reset();
      req = 4'b0001; cdb = 2'b00;
      #1;
      n_total++; if (o_gnt[1] !== 4'b0001) $display("FAIL bp_gnt: got %b want 0001", o_gnt[1]); else n_pass++;
      step();
      req = 4'b0000;
      for (int c = 1; c <= 3; c++) begin
         exp_b = (c == 3) ? 1'b1 : 1'b0;
         #1;
         n_total++; if (o_done[1][0] !== exp_b) $display("FAIL bp_done cyc%0d: got %b want %b", c, o_done[1][0], exp_b); else n_pass++;
         step();
      end
      req = 4'b0010;
      #1;
      n_total++; if (o_iv[1] !== 2'b10) $display("FAIL bp_stall_iv: got %b want 10", o_iv[1]); else n_pass++;
      step();
      req = 4'b0000;
      #1;
      n_total++; if (o_done[1][0] !== 1'b1) $display("FAIL bp_hold_done: got %b want 1", o_done[1][0]); else n_pass++;
      n_total++; if (o_busy[1] !== 2'b11) $display("FAIL bp_hold_busy: got %b want 11", o_busy[1]); else n_pass++;
      step();
      req = 4'b0100; cdb = 2'b01;
      #1;
      n_total++; if (o_gnt[1] !== 4'b0100) $display("FAIL bp_accept_gnt: got %b want 0100", o_gnt[1]); else n_pass++;
      n_total++; if (o_idx[1][1:0] !== 2'd2) $display("FAIL bp_accept_idx: got %0d want 2", o_idx[1][1:0]); else n_pass++;
      step();
      req = 4'b0000; cdb = 2'b00;
      for (int c = 1; c <= 3; c++) begin
         exp_b = (c == 3) ? 1'b1 : 1'b0;
         #1;
         n_total++; if (o_done[1][0] !== exp_b) $display("FAIL bp_redone cyc%0d: got %b want %b", c, o_done[1][0], exp_b); else n_pass++;
         step();
      end
   endtask

   task automatic test_flush();
      do_reset();
      req = 4'b1111; cdb = 2'b11;
      #1;
      n_total++; if (o_gnt[1] !== 4'b0011) $display("FAIL flush_pre_gnt: got %b want 0011", o_gnt[1]); else n_pass++;
      step();
      flush = 1'b1;
      #1;
      n_total++; if (o_gnt[1] !== 4'b0000) $display("FAIL flush_gnt: got %b want 0000", o_gnt[1]); else n_pass++;
      n_total++; if (o_iv[1] !== 2'b00) $display("FAIL flush_iv: got %b want 00", o_iv[1]); else n_pass++;
      step();
      flush = 1'b0;
      #1;
      n_total++; if (o_busy[1] !== 2'b00) $display("FAIL flush_busy: got %b want 00", o_busy[1]); else n_pass++;
      n_total++; if (o_gnt[1] !== 4'b1100) $display("FAIL flush_next_gnt: got %b want 1100", o_gnt[1]); else n_pass++;
      n_total++; if (o_idx[1] !== 4'b1110) $display("FAIL flush_next_idx: got %b want 1110", o_idx[1]); else n_pass++;
      step();
      req = 4'b0000;
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0001; cdb = 2'b00;
      #1;
      step();
      req = 4'b0000;
      step();
      #1;
      n_total++; if (o_busy[1] !== 2'b01) $display("FAIL ares_pre_busy: got %b want 01", o_busy[1]); else n_pass++;
      rst = 1'b0; req = 4'b1111;
      #1;
      n_total++; if (o_busy[1] !== 2'b00) $display("FAIL ares_busy: got %b want 00", o_busy[1]); else n_pass++;
      n_total++; if (o_done[1] !== 2'b00) $display("FAIL ares_done: got %b want 00", o_done[1]); else n_pass++;
      n_total++; if (o_gnt[1] !== 4'b0000) $display("FAIL ares_gnt: got %b want 0000", o_gnt[1]); else n_pass++;
      rst = 1'b1; req = 4'b1000;
      #1;
      n_total++; if (o_gnt[1] !== 4'b1000) $display("FAIL ares_post_gnt: got %b want 1000", o_gnt[1]); else n_pass++;
      n_total++; if (o_idx[1][1:0] !== 2'd3) $display("FAIL ares_post_idx: got %0d want 3", o_idx[1][1:0]); else n_pass++;
      step();
      req = 4'b0000;
   endtask

   task automatic test_oversubscribe();
      do_reset();
      req = 4'b0110; cdb = 2'b01;
      #1;
      n_total++; if (o_gnt[2] !== 4'b0010) $display("FAIL over_gnt0: got %b want 0010", o_gnt[2]); else n_pass++;
      n_total++; if (o_idx[2] !== 4'b0001) $display("FAIL over_idx0: got %b want 0001", o_idx[2]); else n_pass++;
      step();
      req = 4'b0100;
      #1;
      n_total++; if (o_gnt[2] !== 4'b0100) $display("FAIL over_gnt1: got %b want 0100", o_gnt[2]); else n_pass++;
      n_total++; if (o_idx[2] !== 4'b0010) $display("FAIL over_idx1: got %b want 0010", o_idx[2]); else n_pass++;
      step();
      req = 4'b0000;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req   = 4'($urandom);
         cdb   = 2'($urandom);
         flush = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 49) != 0);
         #1;
         model_eval();
         for (int n = 0; n < NI; n++) begin
            n_total++; if (o_gnt[n] !== e_gnt[n]) $display("FAIL rand_gnt inst%0d cyc%0d: got %b want %b", n, c, o_gnt[n], e_gnt[n]); else n_pass++;
            n_total++; if (o_iv[n] !== e_iv[n]) $display("FAIL rand_iv inst%0d cyc%0d: got %b want %b", n, c, o_iv[n], e_iv[n]); else n_pass++;
            n_total++; if (o_idx[n] !== e_idx[n]) $display("FAIL rand_idx inst%0d cyc%0d: got %b want %b", n, c, o_idx[n], e_idx[n]); else n_pass++;
            n_total++; if (o_busy[n] !== e_busy[n]) $display("FAIL rand_busy inst%0d cyc%0d: got %b want %b", n, c, o_busy[n], e_busy[n]); else n_pass++;
            n_total++; if (o_done[n] !== e_done[n]) $display("FAIL rand_done inst%0d cyc%0d: got %b want %b", n, c, o_done[n], e_done[n]); else n_pass++;
         end
         step();
      end
      rst = 1'b1; flush = 1'b0; req = 4'b0000;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b0; flush = 1'b0; req = 4'b0000; cdb = 2'b00;
      test_reset();
      test_basic_issue();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_oversubscribe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
